// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider bank.
// Contents:
//   DIV_W_DEF     default width of the period / high-time / phase fields
//   ST_*          control FSM state encodings (plain constants)
//   ctrl_state_e  the same encodings as an enum, used for the debug state port
//   cfg_t         one channel's configuration record (div, high, phase)
//   def_high      reset high time for a given reset period code
package clk_div_pkg;

  localparam int DIV_W_DEF = 8;

  localparam logic [1:0] ST_RUN_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_RUN_LOCKED   = 2'd1;
  localparam logic [1:0] ST_RESYNC       = 2'd2;

  typedef enum logic [1:0] {
    CTRL_RUN_UNLOCKED = 2'd0,
    CTRL_RUN_LOCKED   = 2'd1,
    CTRL_RESYNC       = 2'd2
  } ctrl_state_e;

  // The record is sized by DIV_W_DEF; a top instantiated with a narrower
  // DIV_W zero-extends into it.
  typedef struct packed {
    logic [DIV_W_DEF-1:0] div;
    logic [DIV_W_DEF-1:0] high;
    logic [DIV_W_DEF-1:0] phase;
  } cfg_t;

  // Roughly 50% duty for the reset period: high = (code+1)/2.
  function automatic logic [DIV_W_DEF-1:0] def_high(input int unsigned def_div);
    return DIV_W_DEF'((def_div + 1) / 2);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel.
// Ports:
//   clk_in1       clock (rising edge)
//   reset_n       asynchronous active-low reset
//   i_load        resync pulse: load the counter with the start phase
//   i_load_div    period code that becomes active with this load
//   i_load_phase  start offset that becomes active with this load
//   i_div         active period code (period = i_div+1)
//   i_high        active high time in cycles
//   o_clk         registered divided clock
module clk_div_chan #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in1,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_div,
  input  logic [DIV_W-1:0] i_load_phase,
  input  logic [DIV_W-1:0] i_div,
  input  logic [DIV_W-1:0] i_high,
  output logic             o_clk
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_clk;

  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else begin
      // cnt < high gives constant 0 for high=0 and constant 1 for high>=period.
      r_clk <= (r_cnt < i_high);
      if (i_load) begin
        // A phase outside the new period starts the channel at 0.
        r_cnt <= (i_load_phase > i_load_div) ? '0 : i_load_phase;
      end else if (r_cnt >= i_div) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign o_clk = r_clk;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable clock dividers sharing one input clock.
// Ports:
//   clk_in1     sole clock (rising edge)
//   reset_n     asynchronous active-low reset
//   cfg_valid   config write request
//   cfg_ready   config write may be accepted (low in reset and in RESYNC)
//   cfg_ch      target channel of the write
//   cfg_div     period code (period = cfg_div+1)
//   cfg_high    high time in cycles
//   cfg_phase   start offset in cycles
//   cfg_apply   pulse: copy every shadow config to active and resync all channels
//   clk_out     registered divided clocks
//   locked      all channels have run on the current config for LOCK_CYCLES cycles
//   cfg_err     sticky flag: a write addressed a channel >= N_CH
//   dbg_state   control FSM state
//
// Handshake: a write transfers on a rising edge where cfg_valid && cfg_ready;
// cfg_valid needs no hold requirement beyond that edge, and cfg_ready does not
// depend on cfg_valid.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEF_DIV     = 1,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in1,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_high,
  input  logic [DIV_W-1:0] cfg_phase,
  input  logic             cfg_apply,
  output logic [N_CH-1:0]  clk_out,
  output logic             locked,
  output logic             cfg_err,
  output ctrl_state_e      dbg_state
);

  localparam int SETTLE_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] LOCK_VAL  = SETTLE_W'(LOCK_CYCLES);
  localparam logic [SETTLE_W-1:0] LOCK_LAST = SETTLE_W'(LOCK_CYCLES - 1);
  // One extra bit so that N_CH itself is representable in the range check.
  localparam logic [CH_W:0] N_CH_EXT = (CH_W + 1)'(N_CH);
  localparam cfg_t RST_CFG = '{
    div:   DIV_W_DEF'(DEF_DIV),
    high:  def_high(DEF_DIV),
    phase: '0
  };

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [SETTLE_W-1:0] r_settle;
  logic                r_err;
  cfg_t                r_shadow [N_CH];
  cfg_t                r_active [N_CH];

  logic                w_wr_acc;
  logic                w_ch_bad;
  logic                w_resync;

  assign cfg_ready = reset_n && (r_state != ST_RESYNC);
  assign w_wr_acc  = cfg_valid && cfg_ready;
  assign w_ch_bad  = ({1'b0, cfg_ch} >= N_CH_EXT);
  assign w_resync  = (r_state == ST_RESYNC);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN_UNLOCKED: begin
        if (cfg_apply)                  w_state_nxt = ST_RESYNC;
        else if (r_settle == LOCK_LAST) w_state_nxt = ST_RUN_LOCKED;
      end
      ST_RUN_LOCKED: begin
        if (cfg_apply) w_state_nxt = ST_RESYNC;
      end
      ST_RESYNC: w_state_nxt = ST_RUN_UNLOCKED;
      default:   w_state_nxt = ST_RUN_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_RUN_UNLOCKED;
      r_settle <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_resync) begin
        r_settle <= '0;
      end else if (r_settle != LOCK_VAL) begin
        // Saturate so a long-running bank never drops lock by wrapping.
        r_settle <= r_settle + SETTLE_W'(1);
      end
      if (w_wr_acc && w_ch_bad) r_err <= 1'b1;
    end
  end

  // Shadow takes writes; active only changes in the single RESYNC cycle, when
  // writes are blocked, so a write and apply in the same cycle are seen in order.
  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_shadow[i] <= RST_CFG;
        r_active[i] <= RST_CFG;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_wr_acc && !w_ch_bad && (cfg_ch == CH_W'(i))) begin
          r_shadow[i] <= '{
            div:   DIV_W_DEF'(cfg_div),
            high:  DIV_W_DEF'(cfg_high),
            phase: DIV_W_DEF'(cfg_phase)
          };
        end
        if (w_resync) r_active[i] <= r_shadow[i];
      end
    end
  end

  // The counters load from shadow in the same cycle active is updated, so
  // every channel restarts on its new config from one common edge.
  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    clk_div_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk_in1      (clk_in1),
      .reset_n      (reset_n),
      .i_load       (w_resync),
      .i_load_div   (DIV_W'(r_shadow[g].div)),
      .i_load_phase (DIV_W'(r_shadow[g].phase)),
      .i_div        (DIV_W'(r_active[g].div)),
      .i_high       (DIV_W'(r_active[g].high)),
      .o_clk        (clk_out[g])
    );
  end

  assign locked    = (r_state == ST_RUN_LOCKED);
  assign cfg_err   = r_err;
  assign dbg_state = ctrl_state_e'(r_state);

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank. Three channels are instantiated so that the
// 2-bit cfg_ch can carry an out-of-range index (3).
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int N_CH  = 3;
  localparam int DIV_W = 8;
  localparam int LOCK  = 16;

  // clock / reset
  logic clk_in1 = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_in1 = ~clk_in1;

  logic             cfg_valid = 1'b0;
  logic             cfg_apply = 1'b0;
  logic [1:0]       cfg_ch    = '0;
  logic [DIV_W-1:0] cfg_div   = '0;
  logic [DIV_W-1:0] cfg_high  = '0;
  logic [DIV_W-1:0] cfg_phase = '0;
  logic             cfg_ready;
  logic             locked;
  logic             cfg_err;
  logic [N_CH-1:0]  clk_out;
  ctrl_state_e      dbg_state;

  clk_div_bank #(
    .N_CH        (N_CH),
    .DIV_W       (DIV_W),
    .DEF_DIV     (1),
    .LOCK_CYCLES (LOCK)
  ) u_dut (
    .clk_in1   (clk_in1),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .cfg_apply (cfg_apply),
    .clk_out   (clk_out),
    .locked    (locked),
    .cfg_err   (cfg_err),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int g_k    = 0;  // rising edges since last resync edge or reset release

  // Expected configuration: period, high time, phase per channel.
  int sh_p [N_CH];
  int sh_h [N_CH];
  int sh_ph[N_CH];
  int ac_p [N_CH];
  int ac_h [N_CH];
  int ac_ph[N_CH];

  task automatic model_defaults();
    for (int i = 0; i < N_CH; i++) begin
      sh_p[i] = 2; sh_h[i] = 1; sh_ph[i] = 0;
      ac_p[i] = 2; ac_h[i] = 1; ac_ph[i] = 0;
    end
  endtask

  // Output after edge k (k>=1): counter value entering edge k compared to H.
  function automatic logic exp_bit(int p, int h, int ph, int k);
    int c0;
    c0 = (ph >= p) ? 0 : ph;
    return (((c0 + k - 1) % p) < h);
  endfunction

  function automatic logic [N_CH-1:0] exp_out(int k);
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i] = exp_bit(ac_p[i], ac_h[i], ac_ph[i], k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_in1);
    #1;
    g_k++;
  endtask

  task automatic check_outs(input string name, input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      checks++;
      if (clk_out !== exp_out(g_k)) begin
        errors++;
        $display("FAIL %s clk_out k=%0d got=%b exp=%b", name, g_k, clk_out, exp_out(g_k));
      end
      checks++;
      if (locked !== (g_k >= LOCK)) begin
        errors++;
        $display("FAIL %s locked k=%0d got=%b exp=%b", name, g_k, locked, (g_k >= LOCK));
      end
    end
  endtask

  task automatic write_cfg(input int ch, input int div, input int high, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = DIV_W'(div);
    cfg_high  = DIV_W'(high);
    cfg_phase = DIV_W'(ph);
    tick();
    cfg_valid = 1'b0;
    if (ch < N_CH) begin
      sh_p[ch] = div + 1; sh_h[ch] = high; sh_ph[ch] = ph;
    end
  endtask

  // Apply pulse; optionally carries a write in the same cycle. hold2 keeps
  // cfg_apply high through the RESYNC cycle, where it must be ignored.
  task automatic apply_cfg(input bit with_wr, input int ch, input int div,
                           input int high, input int ph, input bit hold2);
    if (with_wr) begin
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_div   = DIV_W'(div);
      cfg_high  = DIV_W'(high);
      cfg_phase = DIV_W'(ph);
    end
    cfg_apply = 1'b1;
    tick();
    cfg_valid = 1'b0;
    if (!hold2) cfg_apply = 1'b0;
    if (with_wr && ch < N_CH) begin
      sh_p[ch] = div + 1; sh_h[ch] = high; sh_ph[ch] = ph;
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL apply_locked got=%b exp=0", locked);
    end
    checks++;
    if (dbg_state !== CTRL_RESYNC) begin
      errors++; $display("FAIL apply_state got=%0d exp=2", dbg_state);
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL apply_ready got=%b exp=0", cfg_ready);
    end
    tick();
    cfg_apply = 1'b0;
    g_k = 0;
    for (int i = 0; i < N_CH; i++) begin
      ac_p[i] = sh_p[i]; ac_h[i] = sh_h[i]; ac_ph[i] = sh_ph[i];
    end
    checks++;
    if (dbg_state !== CTRL_RUN_UNLOCKED) begin
      errors++; $display("FAIL resync_exit_state got=%0d exp=0", dbg_state);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL resync_exit_ready got=%b exp=1", cfg_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (clk_out !== '0) begin
      errors++; $display("FAIL %s clk_out got=%b exp=000", name, clk_out);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL %s locked got=%b exp=0", name, locked);
    end
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL %s cfg_err got=%b exp=0", name, cfg_err);
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL %s cfg_ready got=%b exp=0", name, cfg_ready);
    end
    checks++;
    if (dbg_state !== CTRL_RUN_UNLOCKED) begin
      errors++; $display("FAIL %s state got=%0d exp=0", name, dbg_state);
    end
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    model_defaults();
    g_k = 0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready got=%b exp=1", cfg_ready);
    end
  endtask

  // Defaults: period 2, 50% duty on every channel, locked at edge 16.
  task automatic test_reset();
    model_defaults();
    reset_n = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    release_reset();
    check_outs("default_run", 20);
  endtask

  // ch0 period 5 high 2; apply held into RESYNC is ignored; relock after 16.
  task automatic test_ch0_config();
    write_cfg(0, 4, 2, 0);
    apply_cfg(1'b0, 0, 0, 0, 0, 1'b1);
    check_outs("ch0_p5", 20);
  endtask

  // ch1 and ch0 identical (P=4, phase 0); ch2 P=4 phase 2 leads ch1 by 2.
  task automatic test_phase();
    logic [N_CH-1:0] hist [0:12];
    hist[0] = clk_out;
    write_cfg(0, 3, 2, 0);
    write_cfg(1, 3, 2, 0);
    write_cfg(2, 3, 2, 2);
    apply_cfg(1'b0, 0, 0, 0, 0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      check_outs("phase", 1);
      hist[k] = clk_out;
      checks++;
      if (clk_out[0] !== clk_out[1]) begin
        errors++; $display("FAIL phase_same k=%0d ch0=%b ch1=%b", k, clk_out[0], clk_out[1]);
      end
    end
    for (int k = 5; k <= 12; k++) begin
      if (hist[k][1] && !hist[k-1][1]) begin
        checks++;
        if (!(hist[k-2][2] && !hist[k-3][2])) begin
          errors++; $display("FAIL phase_lead ch1_rise=%0d ch2_rise_at_k-2=%b exp=1", k,
                             hist[k-2][2] && !hist[k-3][2]);
        end
      end
    end
  endtask

  // high=0 -> constant 0; high=9 with period 8 -> constant 1.
  task automatic test_constant();
    write_cfg(0, 4, 0, 0);
    write_cfg(1, 7, 9, 0);
    write_cfg(2, 2, 1, 5);  // phase beyond period loads 0
    apply_cfg(1'b0, 0, 0, 0, 0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      check_outs("const", 1);
      checks++;
      if (clk_out[1:0] !== 2'b10) begin
        errors++; $display("FAIL const_lvl k=%0d got=%b exp=10", k, clk_out[1:0]);
      end
    end
  endtask

  // Out-of-range write sets sticky cfg_err and leaves every channel alone;
  // a write in the apply cycle is used by that apply.
  task automatic test_cfg_err();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL err_before got=%b exp=0", cfg_err);
    end
    write_cfg(3, 0, 0, 0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL err_set got=%b exp=1", cfg_err);
    end
    check_outs("err_hold", 4);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got=%b exp=1", cfg_err);
    end
    apply_cfg(1'b1, 2, 1, 1, 0, 1'b0);
    check_outs("wr_apply", 8);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky2 got=%b exp=1", cfg_err);
    end
  endtask

  // Reset during settle clears everything at once and drops pending writes.
  task automatic test_reset_mid_settle();
    write_cfg(2, 5, 3, 1);
    apply_cfg(1'b0, 0, 0, 0, 0, 1'b0);
    check_outs("pre_reset", 5);
    write_cfg(0, 4, 2, 0);  // pending, never applied
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_settle_reset");
    repeat (2) tick();
    release_reset();
    check_outs("post_reset", 20);
    apply_cfg(1'b0, 0, 0, 0, 0, 1'b0);
    check_outs("pending_lost", 6);
  endtask

  initial begin
    test_reset();
    test_ch0_config();
    test_phase();
    test_constant();
    test_cfg_err();
    test_reset_mid_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
